// File: rtl/tmc_reg_access_ctrl.sv
// TMC2130 register access controller: arbitrates two requesters onto one 40-bit SPI
// engine, builds datagrams and runs the two-frame pipelined read.
//
// state   | meaning
// IDLE    | no request in flight, arbitrate on any valid
// GRANT   | ready pulse to winner, request latched, datagram on spi_data_out
// SEND    | enable raised towards the SPI engine
// WAIT_HI | enable held until synchronized busy rises (bounded)
// WAIT_LO | waiting for busy to fall (bounded), then capture or resend for read data
// RESP    | one-cycle response strobe to the granted requester
module tmc_reg_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TO_W           = 5
) (
   input  logic        r_state_clk,
   input  logic        reset_n_in,
   input  logic        req_a_valid,
   input  logic        req_a_write,
   input  logic [6:0]  req_a_addr,
   input  logic [31:0] req_a_wdata,
   output logic        req_a_ready,
   input  logic        req_b_valid,
   input  logic        req_b_write,
   input  logic [6:0]  req_b_addr,
   input  logic [31:0] req_b_wdata,
   output logic        req_b_ready,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic [7:0]  rsp_status,
   output logic        rsp_err,
   output logic [39:0] spi_data_out,
   output logic        spi_enable_out,
   input  logic        spi_busy_in,
   input  logic [39:0] spi_data_in
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SEND,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_RESP
   } state_t;

   // Enable is high for SEND plus the WAIT_HI cycles, so the load value counts SEND too.
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   state_t         state_q;
   logic           busy_meta_q;
   logic           busy_s_q;
   logic           last_grant_q;
   logic           phase_q;
   logic [TO_W-1:0] to_cnt_q;
   logic           id_q;
   logic           write_q;
   logic [7:0]     cap_status_q;
   logic           req_a_ready_q;
   logic           req_b_ready_q;
   logic           rsp_valid_q;
   logic           rsp_id_q;
   logic [31:0]    rsp_data_q;
   logic [7:0]     rsp_status_q;
   logic           rsp_err_q;
   logic [39:0]    spi_data_out_q;
   logic           spi_enable_q;

   logic           grant_b_d;
   logic           sel_write_d;
   logic [6:0]     sel_addr_d;
   logic [31:0]    sel_wdata_d;
   logic           to_expired_d;

   always_ff @(posedge r_state_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
      end else begin
         busy_meta_q <= spi_busy_in;
         busy_s_q    <= busy_meta_q;
      end
   end

   always_comb begin
      grant_b_d    = req_b_valid && (!req_a_valid || !last_grant_q);
      sel_write_d  = grant_b_d ? req_b_write : req_a_write;
      sel_addr_d   = grant_b_d ? req_b_addr  : req_a_addr;
      sel_wdata_d  = grant_b_d ? req_b_wdata : req_a_wdata;
      to_expired_d = (to_cnt_q == '0);
   end

   always_ff @(posedge r_state_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= 1'b1;
         phase_q        <= 1'b0;
         to_cnt_q       <= '0;
         id_q           <= 1'b0;
         write_q        <= 1'b0;
         cap_status_q   <= '0;
         req_a_ready_q  <= 1'b0;
         req_b_ready_q  <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= 1'b0;
         rsp_data_q     <= '0;
         rsp_status_q   <= '0;
         rsp_err_q      <= 1'b0;
         spi_data_out_q <= '0;
         spi_enable_q   <= 1'b0;
      end else begin
         req_a_ready_q <= 1'b0;
         req_b_ready_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_a_valid || req_b_valid) begin
                  req_a_ready_q  <= !grant_b_d;
                  req_b_ready_q  <= grant_b_d;
                  id_q           <= grant_b_d;
                  last_grant_q   <= grant_b_d;
                  write_q        <= sel_write_d;
                  spi_data_out_q <= {sel_write_d, sel_addr_d,
                                     sel_write_d ? sel_wdata_d : 32'h0};
                  phase_q        <= 1'b0;
                  cap_status_q   <= '0;
                  state_q        <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               spi_enable_q <= 1'b1;
               to_cnt_q     <= TO_LOAD;
               state_q      <= ST_SEND;
            end
            ST_SEND: begin
               to_cnt_q <= to_cnt_q - TO_ONE;
               state_q  <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (busy_s_q) begin
                  spi_enable_q <= 1'b0;
                  to_cnt_q     <= TO_LOAD;
                  state_q      <= ST_WAIT_LO;
               end else if (to_expired_d) begin
                  spi_enable_q <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_id_q     <= id_q;
                  rsp_err_q    <= 1'b1;
                  rsp_status_q <= cap_status_q;
                  rsp_data_q   <= '0;
                  state_q      <= ST_RESP;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_ONE;
               end
            end
            ST_WAIT_LO: begin
               if (!busy_s_q) begin
                  cap_status_q <= spi_data_in[39:32];
                  // First read frame only addresses the register; its data belongs to the previous access.
                  if (!write_q && !phase_q) begin
                     phase_q      <= 1'b1;
                     spi_enable_q <= 1'b1;
                     to_cnt_q     <= TO_LOAD;
                     state_q      <= ST_SEND;
                  end else begin
                     rsp_valid_q  <= 1'b1;
                     rsp_id_q     <= id_q;
                     rsp_err_q    <= 1'b0;
                     rsp_status_q <= spi_data_in[39:32];
                     rsp_data_q   <= write_q ? 32'h0 : spi_data_in[31:0];
                     state_q      <= ST_RESP;
                  end
               end else if (to_expired_d) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_id_q     <= id_q;
                  rsp_err_q    <= 1'b1;
                  rsp_status_q <= cap_status_q;
                  rsp_data_q   <= '0;
                  state_q      <= ST_RESP;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_ONE;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               spi_enable_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_a_ready    = req_a_ready_q;
   assign req_b_ready    = req_b_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_id         = rsp_id_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_status     = rsp_status_q;
   assign rsp_err        = rsp_err_q;
   assign spi_data_out   = spi_data_out_q;
   assign spi_enable_out = spi_enable_q;

endmodule

// File: tb/tb_tmc_reg_access_ctrl.sv
// Bench for tmc_reg_access_ctrl: TMC2130-like SPI engine model, two requester
// drivers and a scoreboard of expected responses filled at grant time.
module tb_tmc_reg_access_ctrl;

   localparam int TIMEOUT = 16;

   logic        r_state_clk;
   logic        reset_n_in;
   logic        req_a_valid, req_a_write, req_a_ready;
   logic [6:0]  req_a_addr;
   logic [31:0] req_a_wdata;
   logic        req_b_valid, req_b_write, req_b_ready;
   logic [6:0]  req_b_addr;
   logic [31:0] req_b_wdata;
   logic        rsp_valid, rsp_id, rsp_err;
   logic [31:0] rsp_data;
   logic [7:0]  rsp_status;
   logic [39:0] spi_data_out;
   logic        spi_enable_out;
   logic        spi_busy_in;
   logic [39:0] spi_data_in;

   tmc_reg_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(5)) dut (
      .r_state_clk   (r_state_clk),
      .reset_n_in    (reset_n_in),
      .req_a_valid   (req_a_valid),
      .req_a_write   (req_a_write),
      .req_a_addr    (req_a_addr),
      .req_a_wdata   (req_a_wdata),
      .req_a_ready   (req_a_ready),
      .req_b_valid   (req_b_valid),
      .req_b_write   (req_b_write),
      .req_b_addr    (req_b_addr),
      .req_b_wdata   (req_b_wdata),
      .req_b_ready   (req_b_ready),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_status    (rsp_status),
      .rsp_err       (rsp_err),
      .spi_data_out  (spi_data_out),
      .spi_enable_out(spi_enable_out),
      .spi_busy_in   (spi_busy_in),
      .spi_data_in   (spi_data_in)
   );

   initial r_state_clk = 1'b0;
   always #5 r_state_clk = ~r_state_clk;

   typedef struct packed {
      logic        id;
      logic [39:0] dgram;
      logic [31:0] data;
      logic [7:0]  status;
      logic        err;
      logic [1:0]  bursts;
      logic [31:0] base;
   } exp_t;

   exp_t        sb_q[$];
   logic        grant_log[$];
   logic [31:0] mem [0:127];
   logic [6:0]  prev_addr;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          burst_cnt = 0;
   int          en_len = 0;
   bit          mon_en_prev = 1'b0;
   bit          model_en_prev = 1'b0;
   bit          no_busy = 1'b0;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else n_pass++;
   endtask

   // SPI engine: one cycle after enable rises, busy for 4 cycles; returns status plus
   // the register addressed by the previous datagram.
   initial begin
      spi_busy_in = 1'b0;
      spi_data_in = '0;
      prev_addr   = '0;
      for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
      mem[7'h6F] = 32'h1234_5678;
      forever begin
         logic [39:0] dg;
         @(negedge r_state_clk);
         if (spi_enable_out && !model_en_prev && !no_busy) begin
            dg = spi_data_out;
            @(posedge r_state_clk); #1;
            spi_busy_in = 1'b1;
            spi_data_in = {8'h0B, mem[prev_addr]};
            if (dg[39]) mem[dg[38:32]] = dg[31:0];
            prev_addr = dg[38:32];
            repeat (4) @(posedge r_state_clk);
            #1 spi_busy_in = 1'b0;
         end
         model_en_prev = spi_enable_out;
      end
   end

   always @(negedge r_state_clk) begin
      if (spi_enable_out) begin
         if (!mon_en_prev) begin
            burst_cnt++;
            en_len = 0;
            chk_eq("dgram_sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) chk_eq("spi_data_out", spi_data_out, sb_q[0].dgram);
         end
         en_len++;
      end else if (mon_en_prev && no_busy) begin
         chk_eq("enable_len", en_len, TIMEOUT);
      end
      mon_en_prev = spi_enable_out;

      if (req_a_ready || req_b_ready) chk_eq("ready_onehot", req_a_ready & req_b_ready, 0);

      if (rsp_valid) begin
         exp_t e;
         chk_eq("rsp_sb_nonempty", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_eq("rsp_id", rsp_id, e.id);
            chk_eq("rsp_data", rsp_data, e.data);
            chk_eq("rsp_status", rsp_status, e.status);
            chk_eq("rsp_err", rsp_err, e.err);
            chk_eq("enable_bursts", burst_cnt - e.base, e.bursts);
         end
      end
   end

   task automatic do_req(input bit id, input bit wr, input logic [6:0] addr, input logic [31:0] wd);
      exp_t e;
      bit   got = 1'b0;
      @(posedge r_state_clk); #1;
      if (!id) begin
         req_a_valid = 1'b1; req_a_write = wr; req_a_addr = addr; req_a_wdata = wd;
      end else begin
         req_b_valid = 1'b1; req_b_write = wr; req_b_addr = addr; req_b_wdata = wd;
      end
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge r_state_clk);
         got = id ? req_b_ready : req_a_ready;
      end
      chk_eq("ready_seen", got, 1);
      if (got) begin
         e.id     = id;
         e.dgram  = {wr, addr, wr ? wd : 32'h0};
         e.data   = (wr || no_busy) ? 32'h0 : mem[addr];
         e.status = no_busy ? 8'h00 : 8'h0B;
         e.err    = no_busy;
         e.bursts = (no_busy || wr) ? 2'd1 : 2'd2;
         e.base   = burst_cnt;
         sb_q.push_back(e);
         grant_log.push_back(id);
      end
      @(posedge r_state_clk); #1;
      if (!id) req_a_valid = 1'b0;
      else     req_b_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 1000 && sb_q.size() > 0; t++) @(posedge r_state_clk);
      chk_eq("drain", sb_q.size(), 0);
      repeat (3) @(posedge r_state_clk);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_order [0:5];
      reset_n_in  = 1'b0;
      req_a_valid = 1'b0; req_a_write = 1'b0; req_a_addr = '0; req_a_wdata = '0;
      req_b_valid = 1'b0; req_b_write = 1'b0; req_b_addr = '0; req_b_wdata = '0;
      #12;
      chk_eq("rst_enable", spi_enable_out, 0);
      chk_eq("rst_dout", spi_data_out, 0);
      chk_eq("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_status, rsp_data}, 0);
      chk_eq("rst_ready", {req_a_ready, req_b_ready}, 0);
      #10 reset_n_in = 1'b1;
      repeat (2) @(posedge r_state_clk);

      // A writes CHOPCONF
      do_req(1'b0, 1'b1, 7'h6C, 32'h0001_00C3);
      wait_drain();
      chk_eq("rsp_hold_status", rsp_status, 8'h0B);
      chk_eq("rsp_hold_id", rsp_id, 0);

      // B reads DRV_STATUS over two frames
      do_req(1'b1, 1'b0, 7'h6F, 32'hFFFF_FFFF);
      wait_drain();
      chk_eq("rsp_hold_data", rsp_data, 32'h1234_5678);

      // both requesters contend, three requests each
      grant_log.delete();
      fork
         begin
            do_req(1'b0, 1'b1, 7'h10, 32'hCAFE_0001);
            do_req(1'b0, 1'b1, 7'h11, 32'hCAFE_0002);
            do_req(1'b0, 1'b0, 7'h10, 32'h0);
         end
         begin
            do_req(1'b1, 1'b0, 7'h20, 32'h0);
            do_req(1'b1, 1'b0, 7'h11, 32'h0);
            do_req(1'b1, 1'b1, 7'h21, 32'h0BAD_F00D);
         end
      join
      wait_drain();
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      chk_eq("arb_count", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         chk_eq("arb_order", grant_log[i], exp_order[i]);

      // engine never answers: timeout abort, then normal service
      no_busy = 1'b1;
      do_req(1'b0, 1'b1, 7'h30, 32'h1357_9BDF);
      wait_drain();
      no_busy = 1'b0;
      repeat (2) @(posedge r_state_clk);
      do_req(1'b1, 1'b0, 7'h30, 32'h0);
      wait_drain();

      // reset during the first frame of a B read
      begin
         int b0;
         b0 = burst_cnt;
         do_req(1'b1, 1'b0, 7'h6F, 32'h0);
         for (int t = 0; t < 100 && burst_cnt == b0; t++) @(posedge r_state_clk);
         chk_eq("rst_frame_started", burst_cnt - b0, 1);
      end
      repeat (2) @(posedge r_state_clk);
      #3 reset_n_in = 1'b0;
      #1;
      chk_eq("midrst_enable", spi_enable_out, 0);
      chk_eq("midrst_dout", spi_data_out, 0);
      chk_eq("midrst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_status, rsp_data}, 0);
      sb_q.delete();
      repeat (3) @(posedge r_state_clk);
      #3 reset_n_in = 1'b1;
      for (int t = 0; t < 100 && spi_busy_in; t++) @(posedge r_state_clk);
      chk_eq("engine_idle", spi_busy_in, 0);
      repeat (4) @(posedge r_state_clk);
      grant_log.delete();
      fork
         do_req(1'b0, 1'b0, 7'h6C, 32'h0);
         do_req(1'b1, 1'b1, 7'h22, 32'h2468_ACE0);
      join
      wait_drain();
      chk_eq("post_rst_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk_eq("post_rst_first", grant_log[0], 0);
         chk_eq("post_rst_second", grant_log[1], 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
